// File: rtl/work_dispatcher_pkg.sv
// Shared types and constants for the SHA-256 work dispatcher.
package work_dispatcher_pkg;

  localparam int NONCE_W = 32;
  // One extra bit so a full 2^32 nonce space can be represented.
  localparam int COUNT_W = NONCE_W + 1;

  typedef struct packed {
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] c;
    logic [31:0] d;
    logic [31:0] e;
    logic [31:0] f;
    logic [31:0] g;
    logic [31:0] h;
  } HashState;

  typedef enum logic {
    IDLE,
    RUN
  } dispatch_state_t;

  // A job count of zero stands for the whole 2^32 nonce space.
  function automatic logic [COUNT_W-1:0] job_length(input logic [NONCE_W-1:0] count);
    return (count == '0) ? {1'b1, {NONCE_W{1'b0}}} : {1'b0, count};
  endfunction

endpackage

// File: rtl/work_dispatcher_if.sv
// Job-side and core-side bundle of the work dispatcher.
interface work_dispatcher_if #(
  parameter int NUM_CORES = 4
);
  import work_dispatcher_pkg::*;

  logic                              job_valid;
  logic                              job_ready;
  HashState                          job_hashstate;
  logic [NONCE_W-1:0]                job_w1;
  logic [NONCE_W-1:0]                job_w2;
  logic [NONCE_W-1:0]                job_nonce;
  logic [NONCE_W-1:0]                job_count;
  logic                              hold;
  logic                              flush;
  logic [NUM_CORES-1:0]              core_valid;
  logic [NUM_CORES-1:0]              core_newblock;
  HashState                          core_hashstate;
  logic [NONCE_W-1:0]                core_w1;
  logic [NONCE_W-1:0]                core_w2;
  logic [NUM_CORES-1:0][NONCE_W-1:0] core_w3;
  logic                              busy;
  logic                              done;

  // Dispatcher side.
  modport slave (
    input  job_valid, job_hashstate, job_w1, job_w2, job_nonce, job_count,
    input  hold, flush,
    output job_ready,
    output core_valid, core_newblock, core_hashstate, core_w1, core_w2, core_w3,
    output busy, done
  );

  // Job source / core array side.
  modport master (
    output job_valid, job_hashstate, job_w1, job_w2, job_nonce, job_count,
    output hold, flush,
    input  job_ready,
    input  core_valid, core_newblock, core_hashstate, core_w1, core_w2, core_w3,
    input  busy, done
  );

endinterface

// File: rtl/work_dispatcher_nonce_lane_gen.sv
// Combinational lane generator: spreads the next NUM_CORES nonces over the
// lanes and masks off the lanes beyond the nonces still left in the job.
module nonce_lane_gen
  import work_dispatcher_pkg::*;
#(
  parameter int NUM_CORES = 4
) (
  input  logic [NONCE_W-1:0]                base_i,
  input  logic [COUNT_W-1:0]                remaining_i,
  output logic [NUM_CORES-1:0][NONCE_W-1:0] nonce_o,
  output logic [NUM_CORES-1:0]              mask_o,
  output logic [COUNT_W-1:0]                k_o
);

  localparam logic [COUNT_W-1:0] LANES = COUNT_W'(NUM_CORES);

  assign k_o = (remaining_i < LANES) ? remaining_i : LANES;

  // Lane i carries base+i (wrapping silently) and is live only when i < k.
  always_comb begin
    for (int i = 0; i < NUM_CORES; i++) begin
      nonce_o[i] = base_i + NONCE_W'(i);
      mask_o[i]  = (COUNT_W'(i) < k_o);
    end
  end

endmodule

// File: rtl/work_dispatcher.sv
// Work dispatcher: accepts one mining job per handshake and sweeps its nonce
// range across NUM_CORES core lanes, one beat per non-held cycle.
module work_dispatcher
  import work_dispatcher_pkg::*;
#(
  parameter int NUM_CORES = 4
) (
  input logic           clk,
  input logic           rst,
  work_dispatcher_if.slave bus
);

  localparam logic [COUNT_W-1:0] LANES = COUNT_W'(NUM_CORES);

  dispatch_state_t                   state_q;
  logic [NONCE_W-1:0]                base_q;
  logic [COUNT_W-1:0]                remaining_q;
  logic                              first_q;
  HashState                          job_hs_q;
  logic [NONCE_W-1:0]                job_w1_q;
  logic [NONCE_W-1:0]                job_w2_q;

  logic [NUM_CORES-1:0]              core_valid_q;
  logic [NUM_CORES-1:0]              core_newblock_q;
  HashState                          core_hs_q;
  logic [NONCE_W-1:0]                core_w1_q;
  logic [NONCE_W-1:0]                core_w2_q;
  logic [NUM_CORES-1:0][NONCE_W-1:0] core_w3_q;
  logic                              done_q;

  logic [NUM_CORES-1:0][NONCE_W-1:0] lane_nonce;
  logic [NUM_CORES-1:0]              lane_mask;
  logic [COUNT_W-1:0]                lane_k;
  logic [NONCE_W-1:0]                base_d;
  logic [COUNT_W-1:0]                remaining_d;
  logic                              last_beat;
  logic                              issue;
  logic                              final_beat;
  logic                              ready;
  logic                              accept;

  nonce_lane_gen #(
    .NUM_CORES (NUM_CORES)
  ) u_lane_gen (
    .base_i      (base_q),
    .remaining_i (remaining_q),
    .nonce_o     (lane_nonce),
    .mask_o      (lane_mask),
    .k_o         (lane_k)
  );

  // A job fits in one more beat once no more than NUM_CORES nonces remain,
  // which is also when the next job may be taken on the same edge.
  assign last_beat   = (remaining_q <= LANES);
  assign issue       = (state_q == RUN) && !bus.hold && !bus.flush;
  assign final_beat  = issue && last_beat;
  assign ready       = !rst && !bus.flush &&
                       ((state_q == IDLE) || ((state_q == RUN) && !bus.hold && last_beat));
  assign accept      = bus.job_valid && ready;
  assign base_d      = base_q + lane_k[NONCE_W-1:0];
  assign remaining_d = remaining_q - lane_k;

  // Dispatcher FSM: flush beats everything, otherwise issue the current beat
  // and let an accepted job overwrite the counters for back-to-back issue.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q         <= IDLE;
      base_q          <= '0;
      remaining_q     <= '0;
      first_q         <= 1'b0;
      job_hs_q        <= '0;
      job_w1_q        <= '0;
      job_w2_q        <= '0;
      core_valid_q    <= '0;
      core_newblock_q <= '0;
      core_hs_q       <= '0;
      core_w1_q       <= '0;
      core_w2_q       <= '0;
      core_w3_q       <= '0;
      done_q          <= 1'b0;
    end else if (bus.flush) begin
      state_q         <= IDLE;
      remaining_q     <= '0;
      first_q         <= 1'b0;
      core_valid_q    <= '0;
      core_newblock_q <= '0;
      done_q          <= 1'b0;
    end else begin
      core_valid_q    <= issue ? lane_mask : '0;
      core_newblock_q <= (issue && first_q) ? lane_mask : '0;
      done_q          <= final_beat;
      if (issue) begin
        core_hs_q   <= job_hs_q;
        core_w1_q   <= job_w1_q;
        core_w2_q   <= job_w2_q;
        core_w3_q   <= lane_nonce;
        base_q      <= base_d;
        remaining_q <= remaining_d;
        first_q     <= 1'b0;
      end
      if (accept) begin
        state_q     <= RUN;
        job_hs_q    <= bus.job_hashstate;
        job_w1_q    <= bus.job_w1;
        job_w2_q    <= bus.job_w2;
        base_q      <= bus.job_nonce;
        remaining_q <= job_length(bus.job_count);
        first_q     <= 1'b1;
      end else if (final_beat) begin
        state_q <= IDLE;
      end
    end
  end

  assign bus.job_ready      = ready;
  assign bus.core_valid     = core_valid_q;
  assign bus.core_newblock  = core_newblock_q;
  assign bus.core_hashstate = core_hs_q;
  assign bus.core_w1        = core_w1_q;
  assign bus.core_w2        = core_w2_q;
  assign bus.core_w3        = core_w3_q;
  assign bus.busy           = (state_q == RUN);
  assign bus.done           = done_q;

endmodule

// File: tb/tb_work_dispatcher.sv
// Scoreboard testbench for work_dispatcher with a job-level reference model.
module tb_work_dispatcher;
  import work_dispatcher_pkg::*;

  localparam int     NC   = 4;
  localparam longint FULL = 64'h1_0000_0000;

  typedef struct {
    logic [NC-1:0]         valid;
    logic [NC-1:0]         newblock;
    logic [NC-1:0][31:0]   w3;
    HashState              hs;
    logic [31:0]           w1;
    logic [31:0]           w2;
    logic                  done;
  } beat_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   testsRun = 0;
  int   testsFailed = 0;

  beat_t expQ[$];

  // Reference model: the running job is a nonce range [start, start+total)
  // of which 'issued' nonces have already gone out.
  bit          mActive = 1'b0;
  logic [31:0] mStart = '0;
  longint      mTotal = 0;
  longint      mIssued = 0;
  bit          mFirst = 1'b0;
  HashState    mHs = '0;
  logic [31:0] mW1 = '0;
  logic [31:0] mW2 = '0;

  HashState    lastHs = '0;
  logic [31:0] lastW1 = '0;
  logic [31:0] lastW2 = '0;

  always #5 clk = ~clk;

  work_dispatcher_if #(.NUM_CORES(NC)) bus ();

  work_dispatcher #(.NUM_CORES(NC)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  task automatic checkOutput(input string name, input logic [255:0] got, input logic [255:0] exp);
    testsRun++;
    if (got !== exp) begin
      testsFailed++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, got, exp);
    end
  endtask

  task automatic reportTimeout(input string name);
    testsRun++;
    testsFailed++;
    $display("[TB] FAIL %s: bound expired, expected completion", name);
  endtask

  // Take the next slice of the model's nonce range as one expected beat.
  function automatic void issueBeat();
    beat_t  b;
    longint left = mTotal - mIssued;
    longint k = (left < NC) ? left : NC;
    b.valid    = '0;
    b.newblock = '0;
    b.w3       = '0;
    for (int i = 0; i < NC; i++) begin
      if (i < k) begin
        b.valid[i]    = 1'b1;
        b.newblock[i] = mFirst;
        b.w3[i]       = mStart + 32'(mIssued + i);
      end
    end
    b.hs   = mHs;
    b.w1   = mW1;
    b.w2   = mW2;
    b.done = (mIssued + k == mTotal);
    expQ.push_back(b);
    mIssued += k;
    mFirst = 1'b0;
    if (mIssued == mTotal) mActive = 1'b0;
  endfunction

  // One clock: check job_ready against the model, advance the model at the
  // edge using the inputs the bench is driving, then check busy.
  task automatic stepCycle(output bit accepted);
    bit predReady;
    #1;
    predReady = !rst && !bus.flush &&
                (!mActive || (!bus.hold && (mTotal - mIssued) <= NC));
    checkOutput("job_ready", 256'(bus.job_ready), 256'(predReady));
    accepted = bus.job_valid && predReady;
    @(posedge clk);
    if (bus.flush) begin
      mActive = 1'b0;
    end else begin
      if (mActive && !bus.hold) issueBeat();
      if (accepted) begin
        mActive = 1'b1;
        mStart  = bus.job_nonce;
        mTotal  = (bus.job_count == 0) ? FULL : longint'(bus.job_count);
        mIssued = 0;
        mFirst  = 1'b1;
        mHs     = bus.job_hashstate;
        mW1     = bus.job_w1;
        mW2     = bus.job_w2;
      end
    end
    #1;
    checkOutput("busy", 256'(bus.busy), 256'(mActive));
  endtask

  task automatic step();
    bit a;
    stepCycle(a);
  endtask

  task automatic applyStimulus(input logic [31:0] nonce, input logic [31:0] count);
    bus.job_valid     = 1'b1;
    bus.job_nonce     = nonce;
    bus.job_count     = count;
    bus.job_hashstate = {$urandom(), $urandom(), $urandom(), $urandom(),
                         $urandom(), $urandom(), $urandom(), $urandom()};
    bus.job_w1        = $urandom();
    bus.job_w2        = $urandom();
  endtask

  // Offer a job and keep it offered until the handshake completes.
  task automatic offerJob(input logic [31:0] nonce, input logic [31:0] count);
    bit got = 1'b0;
    applyStimulus(nonce, count);
    for (int n = 0; n < 64 && !got; n++) stepCycle(got);
    if (!got) reportTimeout("job_accept");
    bus.job_valid = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    while ((mActive || expQ.size() != 0) && n < 300) begin
      step();
      n++;
    end
    if (mActive || expQ.size() != 0) reportTimeout("drain");
    step();
  endtask

  // Monitor: every non-reset cycle either presents the next expected beat or
  // must be quiet with the shared data outputs holding their last values.
  always @(negedge clk) begin : monitor
    beat_t e;
    if (!rst) begin
      if (expQ.size() > 0) begin
        e = expQ.pop_front();
        checkOutput("core_valid", 256'(bus.core_valid), 256'(e.valid));
        checkOutput("core_newblock", 256'(bus.core_newblock), 256'(e.newblock));
        for (int i = 0; i < NC; i++)
          if (e.valid[i])
            checkOutput($sformatf("core_w3[%0d]", i), 256'(bus.core_w3[i]), 256'(e.w3[i]));
        checkOutput("core_hashstate", 256'(bus.core_hashstate), 256'(e.hs));
        checkOutput("core_w1w2", 256'({bus.core_w1, bus.core_w2}), 256'({e.w1, e.w2}));
        checkOutput("done", 256'(bus.done), 256'(e.done));
        lastHs = e.hs;
        lastW1 = e.w1;
        lastW2 = e.w2;
      end else begin
        checkOutput("quiet_flags", 256'({bus.core_valid, bus.core_newblock, bus.done}), 256'(0));
        checkOutput("quiet_hashstate", 256'(bus.core_hashstate), 256'(lastHs));
        checkOutput("quiet_w1w2", 256'({bus.core_w1, bus.core_w2}), 256'({lastW1, lastW2}));
      end
    end
  end

  task automatic checkResetOutputs(input string tag);
    checkOutput({tag, "_flags"}, 256'({bus.core_valid, bus.core_newblock, bus.done, bus.busy}), 256'(0));
    checkOutput({tag, "_hashstate"}, 256'(bus.core_hashstate), 256'(0));
    checkOutput({tag, "_w1w2"}, 256'({bus.core_w1, bus.core_w2}), 256'(0));
    checkOutput({tag, "_w3"}, 256'(bus.core_w3), 256'(0));
    checkOutput({tag, "_job_ready"}, 256'(bus.job_ready), 256'(0));
  endtask

  initial begin : watchdog
    #500000;
    $display("[TB] FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin : driver
    bus.job_valid     = 1'b0;
    bus.job_hashstate = '0;
    bus.job_w1        = '0;
    bus.job_w2        = '0;
    bus.job_nonce     = '0;
    bus.job_count     = '0;
    bus.hold          = 1'b0;
    bus.flush         = 1'b0;

    // Reset state.
    @(posedge clk);
    @(posedge clk);
    #1;
    checkResetOutputs("reset");
    rst = 1'b0;

    // Basic job: 10 nonces from 0x100 -> 4 + 4 + 2 lanes, done on the third beat.
    offerJob(32'h0000_0100, 32'd10);
    drain();

    // Same job with a 3-cycle hold after the first beat.
    offerJob(32'h0000_0100, 32'd10);
    step();
    bus.hold = 1'b1;
    repeat (3) step();
    bus.hold = 1'b0;
    drain();

    // Nonce wrap past 0xFFFFFFFF.
    offerJob(32'hFFFF_FFFE, 32'd4);
    drain();

    // Back-to-back: the second job is taken on the first job's final beat.
    offerJob(32'h0000_0200, 32'd6);
    offerJob(32'h0000_0500, 32'd4);
    drain();

    // Flush while beat 2 is on the outputs, with a job offered at the same time.
    offerJob(32'h0000_0300, 32'd16);
    step();
    step();
    applyStimulus(32'h0000_0900, 32'd8);
    bus.flush = 1'b1;
    step();
    bus.flush     = 1'b0;
    bus.job_valid = 1'b0;
    step();
    offerJob(32'h0000_0600, 32'd5);
    drain();

    // Asynchronous reset in the middle of a job.
    offerJob(32'h0000_0ABC, 32'd20);
    step();
    @(negedge clk);
    #2;
    rst = 1'b1;
    #1;
    checkResetOutputs("midjob_reset");
    expQ.delete();
    mActive = 1'b0;
    lastHs  = '0;
    lastW1  = '0;
    lastW2  = '0;
    @(posedge clk);
    @(negedge clk);
    #2;
    rst = 1'b0;

    // Full-space job (count 0) right after release; stays busy until flushed.
    offerJob(32'h7000_0000, 32'd0);
    repeat (3) step();
    repeat (10) step();
    bus.flush = 1'b1;
    step();
    bus.flush = 1'b0;
    drain();

    // Randomised traffic: holds, occasional flushes, nonces near the wrap point.
    for (int c = 0; c < 400; c++) begin
      bus.hold  = ($urandom_range(0, 3) == 0);
      bus.flush = ($urandom_range(0, 40) == 0);
      if ($urandom_range(0, 2) != 0)
        applyStimulus(($urandom_range(0, 3) == 0) ? 32'hFFFF_FFF0 + 32'($urandom_range(0, 15)) : $urandom(),
                      32'($urandom_range(1, 13)));
      else
        bus.job_valid = 1'b0;
      step();
    end
    bus.hold      = 1'b0;
    bus.flush     = 1'b0;
    bus.job_valid = 1'b0;
    drain();

    checkOutput("scoreboard_empty", 256'(expQ.size()), 256'(0));
    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
